pipe_skid_stage: RTL

- Parametrised successor to the fixed IF/ID latch: a generic inter-stage pipeline register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, a one-entry skid buffer so upstream ready is a pure register output, and a flush that injects a NOP bubble.
- Adds a saturating back-pressure counter.
- Carries IR, PC+8 and a parametrised sideband field (control bits, exception/branch-delay tags).

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_sat_counter.sv | 19 +
 rtl/pipe_skid_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and payload layout for the MIPS inter-stage pipeline registers.
package pipe_pkg;

  localparam int IR_W   = 32;
  localparam int PC_W   = 32;
  localparam int SIDE_W = 8;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Payload layout at the default widths; stages built with other widths
  // declare the same field order locally.
  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [PC_W-1:0]   pc8;
    logic [SIDE_W-1:0] side;
  } stage_payload_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline register with a one-entry skid slot, flush-to-NOP
// and a saturating back-pressure counter.
module pipe_skid_stage #(
  parameter int                IR_W     = pipe_pkg::IR_W,
  parameter int                PC_W     = pipe_pkg::PC_W,
  parameter int                SIDE_W   = pipe_pkg::SIDE_W,
  parameter int                CNT_W    = 16,
  parameter logic [IR_W-1:0]   NOP_WORD = IR_W'(pipe_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [PC_W-1:0]   in_pc8,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IR_W-1:0]   out_ir,
  output logic [PC_W-1:0]   out_pc8,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_pkg::*;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [PC_W-1:0]   pc8;
    logic [SIDE_W-1:0] side;
  } payload_t;

  localparam payload_t EMPTY = {NOP_WORD, {PC_W{1'b0}}, {SIDE_W{1'b0}}};

  payload_t m, s, in_pl;
  logic     mv, sv, rdy;
  logic     in_fire, out_fire;

  assign in_pl    = {in_ir, in_pc8, in_side};
  assign in_fire  = in_valid && rdy;
  assign out_fire = mv && out_ready;

  // rdy is kept as its own flop (always equal to !sv) so in_ready has no logic in front of it.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      mv  <= 1'b0;
      sv  <= 1'b0;
      rdy <= 1'b1;
      m   <= EMPTY;
      s   <= EMPTY;
    end else if (!mv) begin
      if (in_fire) begin
        m  <= in_pl;
        mv <= 1'b1;
      end
    end else if (out_fire && sv) begin
      m   <= s;
      sv  <= 1'b0;
      rdy <= 1'b1;
    end else if (out_fire) begin
      if (in_fire) begin
        m <= in_pl;
      end else begin
        mv <= 1'b0;
        m  <= EMPTY;
      end
    end else if (in_fire) begin
      s   <= in_pl;
      sv  <= 1'b1;
      rdy <= 1'b0;
    end
  end

  // M is forced back to EMPTY whenever it goes invalid, so outputs need no masking.
  assign in_ready  = rdy;
  assign out_valid = mv;
  assign out_ir    = m.ir;
  assign out_pc8   = m.pc8;
  assign out_side  = m.side;

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (mv && !out_ready),
    .cnt  (stall_cnt)
  );

  skid_implies_main: assert property (@(posedge clk) disable iff (!reset) !(sv && !mv));

endmodule
